// File: rtl/seq_fsm_param.sv
// seq_fsm_param: cyclic 1..LENGTH position sequencer with restart/pause, up/down direction, parity/terminal flags and lap counter
// Ports: clk, rst_n (async active-low); restart, pause, dir controls;
//   pos (registered position), even/odd (parity of pos), terminal (at end and about to leave or restart),
//   lap (completed cycles, registered), lap_ovf (sticky lap wrap, registered).
// Define SEQ_FSM_SYNC_EN to pass restart/pause/dir through 2-flop synchronisers (3-edge input latency).
module seq_fsm_param #(
  parameter int LENGTH = 3,
  parameter int POS_W  = 8,
  parameter int LAP_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic             pause,
  input  logic             dir,
  output logic [POS_W-1:0] pos,
  output logic             even,
  output logic             odd,
  output logic             terminal,
  output logic [LAP_W-1:0] lap,
  output logic             lap_ovf
);
  localparam logic [POS_W-1:0] LEN = POS_W'(LENGTH);
  localparam logic [POS_W-1:0] ONE = POS_W'(1);
  logic r, p, d;
`ifdef SEQ_FSM_SYNC_EN
  logic [1:0] r_s, p_s, d_s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s <= '0;
      p_s <= '0;
      d_s <= '0;
    end else begin
      r_s <= {r_s[0], restart};
      p_s <= {p_s[0], pause};
      d_s <= {d_s[0], dir};
    end
  assign r = r_s[1];
  assign p = p_s[1];
  assign d = d_s[1];
`else
  assign r = restart;
  assign p = pause;
  assign d = dir;
`endif
  logic [POS_W-1:0] start_pos, end_pos, pos_nx;
  logic [LAP_W-1:0] lap_nx;
  logic             ovf_nx, oor, wrap;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pos     <= ONE;
      lap     <= '0;
      lap_ovf <= 1'b0;
    end else begin
      pos     <= pos_nx;
      lap     <= lap_nx;
      lap_ovf <= ovf_nx;
    end
  always_comb begin
    start_pos = d ? LEN : ONE;
    end_pos   = d ? ONE : LEN;
    oor       = pos == '0 || pos > LEN;
    wrap      = !oor && pos == end_pos && !r && !p;
    pos_nx    = (oor || r || wrap) ? start_pos : p ? pos : d ? pos - ONE : pos + ONE;
    lap_nx    = r ? '0 : wrap ? lap + 1'b1 : lap;
    ovf_nx    = !r && (lap_ovf || (wrap && &lap));
  end
  always_comb begin
    even     = !pos[0];
    odd      = pos[0];
    terminal = pos == end_pos && (r || !p);
  end
endmodule

// File: tb/tb_seq_fsm_param.sv
// tb_seq_fsm_param: randomized self-checking bench for seq_fsm_param against a behavioural model
module tb_seq_fsm_param;
  localparam int L  = 5;
  localparam int LW = 2;
`ifdef SEQ_FSM_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif
  logic clk = 0, rst_n = 0, restart = 0, pause = 0, dir = 0;
  logic [7:0] pos;
  logic [LW-1:0] lap;
  logic even, odd, terminal, lap_ovf;
  int n_chk = 0, n_fail = 0;
  int m_pos = 1, m_lap = 0;
  bit m_ovf = 0;
  bit [2:0] s1 = 0, s2 = 0;
  bit dr = 0;
  seq_fsm_param #(.LENGTH(L), .POS_W(8), .LAP_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .pause(pause), .dir(dir),
    .pos(pos), .even(even), .odd(odd), .terminal(terminal), .lap(lap), .lap_ovf(lap_ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input bit r, input bit p, input bit d);
    bit er, ep, ed;
    int st, en;
    @(negedge clk);
    restart = r;
    pause = p;
    dir = d;
    #1;
    {er, ep, ed} = SYNC ? s2 : {r, p, d};
    st = ed ? L : 1;
    en = ed ? 1 : L;
    chk("pos", pos, m_pos);
    chk("even", even, m_pos % 2 == 0);
    chk("odd", odd, m_pos % 2);
    chk("terminal", terminal, m_pos == en && (er || !ep));
    chk("lap", lap, m_lap);
    chk("lap_ovf", lap_ovf, m_ovf);
    @(posedge clk);
    if (m_pos < 1 || m_pos > L) m_pos = st;
    else if (er) begin
      m_pos = st;
      m_lap = 0;
      m_ovf = 0;
    end else if (!ep) begin
      if (m_pos == en) begin
        m_ovf = m_ovf | (m_lap == (1 << LW) - 1);
        m_lap = (m_lap + 1) % (1 << LW);
      end
      m_pos = ed ? (m_pos + L - 2) % L + 1 : m_pos % L + 1;
    end
    s2 = s1;
    s1 = {r, p, d};
  endtask
  initial begin
    #12;
    chk("rst_pos", pos, 1);
    chk("rst_odd", odd, 1);
    chk("rst_even", even, 0);
    chk("rst_terminal", terminal, 0);
    chk("rst_lap", lap, 0);
    chk("rst_ovf", lap_ovf, 0);
    @(posedge clk);
    #2 rst_n = 1;
    repeat (26) step(0, 0, 0);
    repeat (4) step(0, 1, 0);
    step(1, 1, 0);
    repeat (11) step(0, 0, 1);
    step(1, 0, 0);
    repeat (13) step(0, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("async_pos", pos, 1);
    chk("async_lap", lap, 0);
    chk("async_ovf", lap_ovf, 0);
    m_pos = 1;
    m_lap = 0;
    m_ovf = 0;
    s1 = 0;
    s2 = 0;
    @(posedge clk);
    #2 rst_n = 1;
    repeat (500) begin
      if ($urandom_range(7) == 0) dr = ~dr;
      step($urandom_range(19) == 0, $urandom_range(3) == 0, dr);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
